// File: rtl/ma_xif_router_pkg.sv
// Shared configuration, types and opcode decode for the CV-X-IF router.
// Optional result register slice: MA_XIF_ROUTER_RESULT_REG_EN.
package ma_xif_router_pkg;

    localparam int unsigned NUM_ACC  = 2;
    localparam int unsigned ID_WIDTH = 4;
    localparam int unsigned NUM_RS   = 2;
    localparam int unsigned XLEN     = 64;
    localparam int unsigned ID_DEPTH = 2 ** ID_WIDTH;
    localparam int unsigned CH_W     = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;

    typedef logic [6:0] opcode_t;

    // Major opcode owned by each channel, index 0 in the LSBs.
    localparam opcode_t [NUM_ACC-1:0] OPCODES = {7'h2B, 7'h0B};

    typedef struct packed {
        logic            valid;
        logic [CH_W-1:0] ch_idx;
    } id_entry_t;

    typedef struct packed {
        logic            hit;
        logic [CH_W-1:0] idx;
    } decode_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [XLEN-1:0]     data;
        logic [4:0]          rd;
        logic                we;
    } res_payload_t;

    // Scans downwards so the lowest matching channel is the last one written.
    function automatic decode_t opcode_decode(input opcode_t op);
        decode_t d;
        d = '0;
        for (int i = int'(NUM_ACC) - 1; i >= 0; i--) begin
            if (op == OPCODES[i]) begin
                d.hit = 1'b1;
                d.idx = CH_W'(i);
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/ma_xif_rr_arbiter.sv
// Round-robin arbiter over NUM_ACC requesters; a locked grant is held until
// acknowledged, and the search restarts after the last acknowledged channel.
module ma_xif_rr_arbiter
    import ma_xif_router_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_ACC-1:0] req_i,
    input  logic               lock_i,
    input  logic               ack_i,
    output logic [NUM_ACC-1:0] gnt_onehot_o,
    output logic [CH_W-1:0]    gnt_idx_o
);

    logic [CH_W-1:0] ptr_q, ptr_d;
    logic [CH_W-1:0] held_q, held_d;
    logic            locked_q, locked_d;
    logic [CH_W-1:0] pick_idx;
    logic [CH_W-1:0] cand;
    logic            found;
    logic            gnt_valid;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        found    = 1'b0;
        pick_idx = ptr_q;
        cand     = ptr_q;
        for (int i = 0; i < int'(NUM_ACC); i++) begin
            cand = CH_W'((int'(ptr_q) + i) % int'(NUM_ACC));
            if (!found && req_i[cand]) begin
                found    = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign gnt_idx_o    = locked_q ? held_q : pick_idx;
    assign gnt_valid    = locked_q ? req_i[held_q] : found;
    assign gnt_onehot_o = gnt_valid ? (NUM_ACC'(1) << gnt_idx_o) : '0;

    always_comb begin
        ptr_d    = ptr_q;
        held_d   = gnt_idx_o;
        locked_d = lock_i && gnt_valid;
        if (ack_i) begin
            ptr_d = (gnt_idx_o == CH_W'(NUM_ACC - 1)) ? '0 : gnt_idx_o + CH_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            held_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            held_q   <= held_d;
            locked_q <= locked_d;
        end
    end

endmodule

// File: rtl/ma_xif_router.sv
// Fans one core CV-X-IF port out to NUM_ACC coprocessors with ID ownership tracking.
// Define MA_XIF_ROUTER_RESULT_REG_EN to add a register slice on the core result side.
module ma_xif_router
    import ma_xif_router_pkg::*;
(
    input  logic                                       clk,
    input  logic                                       rst_n,
    // core issue
    input  logic                                       c_issue_valid_i,
    output logic                                       c_issue_ready_o,
    input  logic [31:0]                                c_issue_instr_i,
    input  logic [ID_WIDTH-1:0]                        c_issue_id_i,
    output logic                                       c_issue_accept_o,
    output logic                                       c_issue_writeback_o,
    // core register
    input  logic                                       c_reg_valid_i,
    output logic                                       c_reg_ready_o,
    input  logic [ID_WIDTH-1:0]                        c_reg_id_i,
    input  logic [NUM_RS-1:0][XLEN-1:0]                c_reg_rs_i,
    input  logic [NUM_RS-1:0]                          c_reg_rs_valid_i,
    // core commit
    input  logic                                       c_commit_valid_i,
    input  logic [ID_WIDTH-1:0]                        c_commit_id_i,
    input  logic                                       c_commit_kill_i,
    // core result
    output logic                                       c_res_valid_o,
    input  logic                                       c_res_ready_i,
    output logic [ID_WIDTH-1:0]                        c_res_id_o,
    output logic [XLEN-1:0]                            c_res_data_o,
    output logic [4:0]                                 c_res_rd_o,
    output logic                                       c_res_we_o,
    // accelerator issue
    output logic [NUM_ACC-1:0]                         a_issue_valid_o,
    input  logic [NUM_ACC-1:0]                         a_issue_ready_i,
    output logic [NUM_ACC-1:0][31:0]                   a_issue_instr_o,
    output logic [NUM_ACC-1:0][ID_WIDTH-1:0]           a_issue_id_o,
    input  logic [NUM_ACC-1:0]                         a_issue_accept_i,
    input  logic [NUM_ACC-1:0]                         a_issue_writeback_i,
    // accelerator register
    output logic [NUM_ACC-1:0]                         a_reg_valid_o,
    input  logic [NUM_ACC-1:0]                         a_reg_ready_i,
    output logic [NUM_ACC-1:0][ID_WIDTH-1:0]           a_reg_id_o,
    output logic [NUM_ACC-1:0][NUM_RS-1:0][XLEN-1:0]   a_reg_rs_o,
    output logic [NUM_ACC-1:0][NUM_RS-1:0]             a_reg_rs_valid_o,
    // accelerator commit
    output logic [NUM_ACC-1:0]                         a_commit_valid_o,
    output logic [NUM_ACC-1:0][ID_WIDTH-1:0]           a_commit_id_o,
    output logic [NUM_ACC-1:0]                         a_commit_kill_o,
    // accelerator result
    input  logic [NUM_ACC-1:0]                         a_res_valid_i,
    output logic [NUM_ACC-1:0]                         a_res_ready_o,
    input  logic [NUM_ACC-1:0][ID_WIDTH-1:0]           a_res_id_i,
    input  logic [NUM_ACC-1:0][XLEN-1:0]               a_res_data_i,
    input  logic [NUM_ACC-1:0][4:0]                    a_res_rd_i,
    input  logic [NUM_ACC-1:0]                         a_res_we_i,
    output logic                                       err_o
);

    id_entry_t           table_q [ID_DEPTH];
    id_entry_t           table_d [ID_DEPTH];
    logic                err_q, err_d;

    decode_t             dec;
    logic                issue_alloc;
    id_entry_t           reg_owner;
    id_entry_t           cm_owner;
    logic                commit_free;

    logic [NUM_ACC-1:0]  gnt_onehot;
    logic [CH_W-1:0]     gnt_idx;
    logic                gnt_valid;
    logic                acc_hs;
    res_payload_t        sel_pl;
    logic                res_free;
    logic [ID_WIDTH-1:0] res_free_id;

    assign dec = opcode_decode(c_issue_instr_i[6:0]);

    // Payloads are broadcast; only the valid strobes are steered.
    assign a_issue_instr_o  = {NUM_ACC{c_issue_instr_i}};
    assign a_issue_id_o     = {NUM_ACC{c_issue_id_i}};
    assign a_reg_id_o       = {NUM_ACC{c_reg_id_i}};
    assign a_reg_rs_o       = {NUM_ACC{c_reg_rs_i}};
    assign a_reg_rs_valid_o = {NUM_ACC{c_reg_rs_valid_i}};
    assign a_commit_id_o    = {NUM_ACC{c_commit_id_i}};
    assign a_commit_kill_o  = {NUM_ACC{c_commit_kill_i}};

    // Issue steering; unowned opcodes are rejected locally in the same cycle.
    always_comb begin
        a_issue_valid_o     = '0;
        c_issue_ready_o     = c_issue_valid_i;
        c_issue_accept_o    = 1'b0;
        c_issue_writeback_o = 1'b0;
        if (dec.hit) begin
            a_issue_valid_o[dec.idx] = c_issue_valid_i;
            c_issue_ready_o          = a_issue_ready_i[dec.idx];
            c_issue_accept_o         = a_issue_accept_i[dec.idx];
            c_issue_writeback_o      = a_issue_writeback_i[dec.idx];
        end
    end

    assign issue_alloc = c_issue_valid_i && c_issue_ready_o && c_issue_accept_o;

    // Register steering with bypass of an accept happening this same cycle.
    always_comb begin
        reg_owner     = table_q[c_reg_id_i];
        a_reg_valid_o = '0;
        c_reg_ready_o = c_reg_valid_i;
        if (issue_alloc && (c_issue_id_i == c_reg_id_i)) begin
            reg_owner = '{valid: 1'b1, ch_idx: dec.idx};
        end
        if (reg_owner.valid) begin
            a_reg_valid_o[reg_owner.ch_idx] = c_reg_valid_i;
            c_reg_ready_o                   = a_reg_ready_i[reg_owner.ch_idx];
        end
    end

    always_comb begin
        cm_owner         = table_q[c_commit_id_i];
        a_commit_valid_o = '0;
        if (cm_owner.valid) begin
            a_commit_valid_o[cm_owner.ch_idx] = c_commit_valid_i;
        end
    end

    assign commit_free = c_commit_valid_i && cm_owner.valid && c_commit_kill_i;

    ma_xif_rr_arbiter u_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (a_res_valid_i),
        .lock_i       (gnt_valid && !acc_hs),
        .ack_i        (acc_hs),
        .gnt_onehot_o (gnt_onehot),
        .gnt_idx_o    (gnt_idx)
    );

    assign gnt_valid = |gnt_onehot;
    assign sel_pl    = '{id:   a_res_id_i[gnt_idx],
                         data: a_res_data_i[gnt_idx],
                         rd:   a_res_rd_i[gnt_idx],
                         we:   a_res_we_i[gnt_idx]};

`ifdef MA_XIF_ROUTER_RESULT_REG_EN
    res_payload_t slice_q;
    logic         slice_full_q;
    logic         slice_take;

    // Slice accepts a new beat whenever it is empty or draining this cycle.
    assign slice_take    = !slice_full_q || c_res_ready_i;
    assign acc_hs        = gnt_valid && slice_take;
    assign a_res_ready_o = slice_take ? gnt_onehot : '0;
    assign c_res_valid_o = slice_full_q;
    assign c_res_id_o    = slice_q.id;
    assign c_res_data_o  = slice_q.data;
    assign c_res_rd_o    = slice_q.rd;
    assign c_res_we_o    = slice_q.we;
    assign res_free      = slice_full_q && c_res_ready_i;
    assign res_free_id   = slice_q.id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slice_q      <= '0;
            slice_full_q <= 1'b0;
        end else if (acc_hs) begin
            slice_q      <= sel_pl;
            slice_full_q <= 1'b1;
        end else if (c_res_ready_i) begin
            slice_full_q <= 1'b0;
        end
    end
`else
    assign acc_hs        = gnt_valid && c_res_ready_i;
    assign a_res_ready_o = c_res_ready_i ? gnt_onehot : '0;
    assign c_res_valid_o = gnt_valid;
    assign c_res_id_o    = sel_pl.id;
    assign c_res_data_o  = sel_pl.data;
    assign c_res_rd_o    = sel_pl.rd;
    assign c_res_we_o    = sel_pl.we;
    assign res_free      = acc_hs;
    assign res_free_id   = sel_pl.id;
`endif

    // Frees first, then allocation, so a same-cycle allocate wins.
    always_comb begin
        table_d = table_q;
        err_d   = err_q;
        if (commit_free) begin
            table_d[c_commit_id_i].valid = 1'b0;
        end
        if (res_free) begin
            table_d[res_free_id].valid = 1'b0;
        end
        if (issue_alloc) begin
            if (table_d[c_issue_id_i].valid) begin
                err_d = 1'b1;
            end
            table_d[c_issue_id_i] = '{valid: 1'b1, ch_idx: dec.idx};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ID_DEPTH); i++) begin
                table_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            table_q <= table_d;
            err_q   <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_ma_xif_router.sv
// Directed bench for ma_xif_router: issue/register/commit steering, ID table,
// result arbitration and the optional result slice (MA_XIF_ROUTER_RESULT_REG_EN).
module tb_ma_xif_router;
    import ma_xif_router_pkg::*;

`ifdef MA_XIF_ROUTER_RESULT_REG_EN
    localparam bit SLICE = 1'b1;
`else
    localparam bit SLICE = 1'b0;
`endif

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [XLEN-1:0]     data;
    } tr_t;

    logic                                     clk, rst_n;
    logic                                     c_issue_valid_i, c_issue_ready_o;
    logic [31:0]                              c_issue_instr_i;
    logic [ID_WIDTH-1:0]                      c_issue_id_i;
    logic                                     c_issue_accept_o, c_issue_writeback_o;
    logic                                     c_reg_valid_i, c_reg_ready_o;
    logic [ID_WIDTH-1:0]                      c_reg_id_i;
    logic [NUM_RS-1:0][XLEN-1:0]              c_reg_rs_i;
    logic [NUM_RS-1:0]                        c_reg_rs_valid_i;
    logic                                     c_commit_valid_i, c_commit_kill_i;
    logic [ID_WIDTH-1:0]                      c_commit_id_i;
    logic                                     c_res_valid_o, c_res_ready_i, c_res_we_o;
    logic [ID_WIDTH-1:0]                      c_res_id_o;
    logic [XLEN-1:0]                          c_res_data_o;
    logic [4:0]                               c_res_rd_o;
    logic [NUM_ACC-1:0]                       a_issue_valid_o, a_issue_ready_i;
    logic [NUM_ACC-1:0][31:0]                 a_issue_instr_o;
    logic [NUM_ACC-1:0][ID_WIDTH-1:0]         a_issue_id_o;
    logic [NUM_ACC-1:0]                       a_issue_accept_i, a_issue_writeback_i;
    logic [NUM_ACC-1:0]                       a_reg_valid_o, a_reg_ready_i;
    logic [NUM_ACC-1:0][ID_WIDTH-1:0]         a_reg_id_o;
    logic [NUM_ACC-1:0][NUM_RS-1:0][XLEN-1:0] a_reg_rs_o;
    logic [NUM_ACC-1:0][NUM_RS-1:0]           a_reg_rs_valid_o;
    logic [NUM_ACC-1:0]                       a_commit_valid_o, a_commit_kill_o;
    logic [NUM_ACC-1:0][ID_WIDTH-1:0]         a_commit_id_o;
    logic [NUM_ACC-1:0]                       a_res_valid_i, a_res_ready_o, a_res_we_i;
    logic [NUM_ACC-1:0][ID_WIDTH-1:0]         a_res_id_i;
    logic [NUM_ACC-1:0][XLEN-1:0]             a_res_data_i;
    logic [NUM_ACC-1:0][4:0]                  a_res_rd_i;
    logic                                     err_o;

    int  checks = 0;
    int  errors = 0;
    tr_t sb[$];
    tr_t q0[$];
    tr_t q1[$];
    logic hs0, hs1;

    ma_xif_router dut (
        .clk(clk), .rst_n(rst_n),
        .c_issue_valid_i(c_issue_valid_i), .c_issue_ready_o(c_issue_ready_o),
        .c_issue_instr_i(c_issue_instr_i), .c_issue_id_i(c_issue_id_i),
        .c_issue_accept_o(c_issue_accept_o), .c_issue_writeback_o(c_issue_writeback_o),
        .c_reg_valid_i(c_reg_valid_i), .c_reg_ready_o(c_reg_ready_o), .c_reg_id_i(c_reg_id_i),
        .c_reg_rs_i(c_reg_rs_i), .c_reg_rs_valid_i(c_reg_rs_valid_i),
        .c_commit_valid_i(c_commit_valid_i), .c_commit_id_i(c_commit_id_i),
        .c_commit_kill_i(c_commit_kill_i),
        .c_res_valid_o(c_res_valid_o), .c_res_ready_i(c_res_ready_i), .c_res_id_o(c_res_id_o),
        .c_res_data_o(c_res_data_o), .c_res_rd_o(c_res_rd_o), .c_res_we_o(c_res_we_o),
        .a_issue_valid_o(a_issue_valid_o), .a_issue_ready_i(a_issue_ready_i),
        .a_issue_instr_o(a_issue_instr_o), .a_issue_id_o(a_issue_id_o),
        .a_issue_accept_i(a_issue_accept_i), .a_issue_writeback_i(a_issue_writeback_i),
        .a_reg_valid_o(a_reg_valid_o), .a_reg_ready_i(a_reg_ready_i), .a_reg_id_o(a_reg_id_o),
        .a_reg_rs_o(a_reg_rs_o), .a_reg_rs_valid_o(a_reg_rs_valid_o),
        .a_commit_valid_o(a_commit_valid_o), .a_commit_id_o(a_commit_id_o),
        .a_commit_kill_o(a_commit_kill_o),
        .a_res_valid_i(a_res_valid_i), .a_res_ready_o(a_res_ready_o), .a_res_id_i(a_res_id_i),
        .a_res_data_i(a_res_data_i), .a_res_rd_i(a_res_rd_i), .a_res_we_i(a_res_we_i),
        .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drive_issue(input logic v, input logic [6:0] op, input logic [ID_WIDTH-1:0] id);
        c_issue_valid_i = v;
        c_issue_instr_i = {25'h0, op};
        c_issue_id_i    = id;
    endtask

    task automatic drive_reg(input logic v, input logic [ID_WIDTH-1:0] id);
        c_reg_valid_i = v;
        c_reg_id_i    = id;
    endtask

    task automatic drive_commit(input logic v, input logic [ID_WIDTH-1:0] id, input logic k);
        c_commit_valid_i = v;
        c_commit_id_i    = id;
        c_commit_kill_i  = k;
    endtask

    task automatic wait_sb(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("sb_drain", 64'(sb.size()), 64'd0);
        tick();
    endtask

    // Core-side scoreboard and accelerator handshake sampling.
    always @(negedge clk) begin
        hs0 = a_res_valid_i[0] && a_res_ready_o[0];
        hs1 = a_res_valid_i[1] && a_res_ready_o[1];
        if (rst_n && c_res_valid_o && c_res_ready_i) begin
            if (sb.size() == 0) begin
                chk("res_unexpected", 64'd1, 64'd0);
            end else begin
                tr_t e;
                e = sb.pop_front();
                chk("res_id", 64'(c_res_id_o), 64'(e.id));
                chk("res_data", c_res_data_o, e.data);
            end
        end
    end

    // Accelerator result drivers: each channel presents the head of its queue.
    always @(posedge clk) begin
        #2;
        if (hs0 && q0.size() != 0) void'(q0.pop_front());
        if (hs1 && q1.size() != 0) void'(q1.pop_front());
        hs0 = 1'b0;
        hs1 = 1'b0;
        a_res_valid_i[0] = (q0.size() != 0);
        a_res_valid_i[1] = (q1.size() != 0);
        if (q0.size() != 0) begin
            a_res_id_i[0] = q0[0].id; a_res_data_i[0] = q0[0].data;
        end
        if (q1.size() != 0) begin
            a_res_id_i[1] = q1[0].id; a_res_data_i[1] = q1[0].data;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        drive_issue(1'b0, 7'h0, '0);
        drive_reg(1'b0, '0);
        drive_commit(1'b0, '0, 1'b0);
        c_reg_rs_i = '0; c_reg_rs_valid_i = '0; c_res_ready_i = 1'b0;
        a_issue_ready_i = '0; a_issue_accept_i = '0; a_issue_writeback_i = '0; a_reg_ready_i = '0;
        a_res_valid_i = '0; a_res_id_i = '0; a_res_data_i = '0; a_res_rd_i = '0; a_res_we_i = '1;

        settle();
        chk("rst_issue_ready", 64'(c_issue_ready_o), 64'd0);
        chk("rst_reg_ready", 64'(c_reg_ready_o), 64'd0);
        chk("rst_res_valid", 64'(c_res_valid_o), 64'd0);
        chk("rst_a_res_ready", 64'(a_res_ready_o), 64'd0);
        chk("rst_a_issue_valid", 64'(a_issue_valid_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        rst_n = 1'b1;
        tick();
        a_issue_ready_i = 2'b11; a_issue_accept_i = 2'b11;
        a_issue_writeback_i = 2'b10; a_reg_ready_i = 2'b11;

        // Issue to ch1 and register follow-up
        drive_issue(1'b1, 7'h2B, 4'd3);
        settle();
        chk("t1_a_issue_valid", 64'(a_issue_valid_o), 64'b10);
        chk("t1_issue_ready", 64'(c_issue_ready_o), 64'd1);
        chk("t1_accept", 64'(c_issue_accept_o), 64'd1);
        chk("t1_writeback", 64'(c_issue_writeback_o), 64'd1);
        tick();
        drive_issue(1'b0, 7'h0, '0);
        drive_reg(1'b1, 4'd3);
        c_reg_rs_i[0] = 64'h1111_2222_3333_4444;
        settle();
        chk("t1_a_reg_valid", 64'(a_reg_valid_o), 64'b10);
        chk("t1_reg_ready", 64'(c_reg_ready_o), 64'd1);
        chk("t1_a_reg_rs", a_reg_rs_o[1][0], 64'h1111_2222_3333_4444);
        tick();

        // Same-cycle bypass of a fresh ch0 allocation
        drive_issue(1'b1, 7'h0B, 4'd7);
        drive_reg(1'b1, 4'd7);
        settle();
        chk("byp_a_issue_valid", 64'(a_issue_valid_o), 64'b01);
        chk("byp_writeback", 64'(c_issue_writeback_o), 64'd0);
        chk("byp_a_reg_valid", 64'(a_reg_valid_o), 64'b01);
        tick();
        drive_issue(1'b0, 7'h0, '0);

        // Unowned opcode and register for its id
        drive_reg(1'b0, '0);
        drive_issue(1'b1, 7'h33, 4'd9);
        settle();
        chk("t2_issue_ready", 64'(c_issue_ready_o), 64'd1);
        chk("t2_accept", 64'(c_issue_accept_o), 64'd0);
        chk("t2_a_issue_valid", 64'(a_issue_valid_o), 64'd0);
        tick();
        drive_issue(1'b0, 7'h0, '0);
        drive_reg(1'b1, 4'd9);
        settle();
        chk("t2_reg_ready", 64'(c_reg_ready_o), 64'd1);
        chk("t2_a_reg_valid", 64'(a_reg_valid_o), 64'd0);
        tick();
        drive_reg(1'b0, '0);

        // Commit with kill frees id 3
        drive_commit(1'b1, 4'd3, 1'b1);
        settle();
        chk("t4_a_commit_valid", 64'(a_commit_valid_o), 64'b10);
        tick();
        drive_commit(1'b0, '0, 1'b0);
        drive_reg(1'b1, 4'd3);
        settle();
        chk("t4_commit_pulse_end", 64'(a_commit_valid_o), 64'd0);
        chk("t4_freed_a_reg_valid", 64'(a_reg_valid_o), 64'd0);
        chk("t4_freed_reg_ready", 64'(c_reg_ready_o), 64'd1);
        tick();
        drive_reg(1'b0, '0);
        drive_issue(1'b1, 7'h2B, 4'd3);
        tick();
        drive_issue(1'b0, 7'h0, '0);
        settle();
        chk("t4_reissue_err", 64'(err_o), 64'd0);
        tick();
        drive_commit(1'b1, 4'd7, 1'b0);
        settle();
        chk("t4_commit7", 64'(a_commit_valid_o), 64'b01);
        tick();
        drive_commit(1'b0, '0, 1'b0);
        drive_reg(1'b1, 4'd7);
        settle();
        chk("t4_kept_a_reg_valid", 64'(a_reg_valid_o), 64'b01);
        tick();
        drive_reg(1'b0, '0);

        // Simultaneous results: ch0 first, then ch1
        c_res_ready_i = 1'b1;
        q0.push_back('{id: 4'd7, data: 64'hA0}); sb.push_back('{id: 4'd7, data: 64'hA0});
        q1.push_back('{id: 4'd3, data: 64'hB1}); sb.push_back('{id: 4'd3, data: 64'hB1});
        settle();
        chk("t3_first_grant", 64'(a_res_ready_o), 64'b01);
        chk("t3_res_valid_lat", 64'(c_res_valid_o), SLICE ? 64'd0 : 64'd1);
        tick();
        settle();
        chk("t3_second_grant", 64'(a_res_ready_o), 64'b10);
        wait_sb(20);
        drive_reg(1'b1, 4'd7);
        settle();
        chk("t3_res_freed", 64'(a_reg_valid_o), 64'd0);
        tick();
        drive_reg(1'b0, '0);

        // Held ch1 result keeps its grant while ch0 arrives
        c_res_ready_i = 1'b0;
        q1.push_back('{id: 4'hC, data: 64'hC2}); sb.push_back('{id: 4'hC, data: 64'hC2});
        tick();
        q0.push_back('{id: 4'hD, data: 64'hD3}); sb.push_back('{id: 4'hD, data: 64'hD3});
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t3_hold_valid", 64'(c_res_valid_o), 64'd1);
            chk("t3_hold_id", 64'(c_res_id_o), 64'hC);
            chk("t3_hold_data", c_res_data_o, 64'hC2);
            chk("t3_hold_ready", 64'(a_res_ready_o), 64'd0);
            tick();
        end
        c_res_ready_i = 1'b1;
        wait_sb(20);

        // Back-to-back results from ch0
        for (int i = 0; i < 3; i++) begin
            tr_t t;
            t = '{id: ID_WIDTH'(i + 1), data: 64'h100 + 64'(i)};
            q0.push_back(t);
            sb.push_back(t);
        end
        settle();
        chk("t6_c0", 64'(c_res_valid_o), SLICE ? 64'd0 : 64'd1);
        tick(); settle();
        chk("t6_c1", 64'(c_res_valid_o), 64'd1);
        tick(); settle();
        chk("t6_c2", 64'(c_res_valid_o), 64'd1);
        tick(); settle();
        chk("t6_c3", 64'(c_res_valid_o), SLICE ? 64'd1 : 64'd0);
        tick();
        wait_sb(20);

        // ID reuse sets a sticky error, cleared only by reset
        drive_issue(1'b1, 7'h0B, 4'd5);
        tick();
        drive_issue(1'b0, 7'h0, '0);
        settle();
        chk("t5_first_err", 64'(err_o), 64'd0);
        tick();
        drive_issue(1'b1, 7'h0B, 4'd5);
        tick();
        drive_issue(1'b0, 7'h0, '0);
        settle();
        chk("t5_dup_err", 64'(err_o), 64'd1);
        repeat (3) tick();
        settle();
        chk("t5_sticky_err", 64'(err_o), 64'd1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("t5_async_clear", 64'(err_o), 64'd0);
        settle();
        rst_n = 1'b1;
        tick();
        drive_reg(1'b1, 4'd5);
        settle();
        chk("rst_table_cleared", 64'(a_reg_valid_o), 64'd0);
        chk("rst_table_ready", 64'(c_reg_ready_o), 64'd1);
        tick();
        drive_reg(1'b0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
